// File: rtl/pipeline_retire_tracker_pkg.sv
// Shared types for the retire tracker.
//   trace_rec_t : one retire record as seen by the trace consumer
//   slot_t      : per-stage pipeline slot (record minus retire_cyc, plus valid)
//   STALL_SAT   : saturation value of the per-instruction stall counter
// No ports; imported by the tracker, its interface and its FIFO user.
package wisc_trace_pkg;

  localparam int ADDR_W = 16;
  localparam int CYC_W  = 32;
  localparam int SEQ_W  = 16;

  localparam logic [3:0] STALL_SAT = 4'hF;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] instr;
    logic [CYC_W-1:0]  fetch_cyc;
    logic [CYC_W-1:0]  retire_cyc;
    logic [3:0]        stall_cyc;
  } trace_rec_t;

  typedef struct packed {
    logic              valid;
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] instr;
    logic [CYC_W-1:0]  fetch_cyc;
    logic [3:0]        stall_cyc;
  } slot_t;

  // Stamp a retiring slot with the cycle it writes back on.
  function automatic trace_rec_t slot_to_rec(input slot_t s, input logic [CYC_W-1:0] cyc);
    trace_rec_t r;
    r.seq        = s.seq;
    r.pc         = s.pc;
    r.instr      = s.instr;
    r.fetch_cyc  = s.fetch_cyc;
    r.retire_cyc = cyc;
    r.stall_cyc  = s.stall_cyc;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_retire_tracker_if.sv
// Bus between the WISC pipeline/trace consumer and the retire tracker.
//   if_valid/if_pc/if_instr : fetch stage contents
//   stall/flush             : pipeline control seen by IF/ID
//   out_valid/out_ready/out_rec : retire record stream
//   overflow/drop_cnt/cycle : status
// Handshake: a record transfers on a rising edge where out_valid && out_ready;
// while out_valid && !out_ready the record on out_rec does not change, and
// out_valid never depends combinationally on out_ready.
// Modports: master = tracker side, slave = pipeline/consumer side.
interface pipeline_retire_tracker_if;
  import wisc_trace_pkg::*;

  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_instr;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  trace_rec_t        out_rec;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic [CYC_W-1:0]  cycle;

  modport master (
    input  if_valid, if_pc, if_instr, stall, flush, out_ready,
    output out_valid, out_rec, overflow, drop_cnt, cycle
  );

  modport slave (
    output if_valid, if_pc, if_instr, stall, flush, out_ready,
    input  out_valid, out_rec, overflow, drop_cnt, cycle
  );
endinterface

// File: rtl/pipeline_retire_tracker_trace_fifo.sv
// trace_fifo: synchronous FIFO of DEPTH entries of type T.
//   push/push_data/full : write side; a push while full is accepted only
//                         when a pop happens on the same edge
//   out_valid/out_ready/out_data : read side, registered valid, no bypass
// Asynchronous active-low reset empties the FIFO.
module trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  output logic full,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop;
  logic        wr_en;

  // Extra pointer bit distinguishes full from empty.
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/pipeline_retire_tracker.sv
// pipeline_retire_tracker: follows each fetched instruction through the
// ID/EX/MEM/WB slots of the WISC 5-stage pipeline and emits one retire record
// per instruction into a small FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master modport (fetch/stall/flush in, record stream and status out)
// The WB stage has no register of its own: the edge that moves an instruction
// from MEM into WB is the edge that writes its record into the FIFO.
module pipeline_retire_tracker
  import wisc_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pipeline_retire_tracker_if.master  bus
);

  slot_t            id_q;
  slot_t            ex_q;
  slot_t            mem_q;
  logic [CYC_W-1:0] cycle_q;
  logic [SEQ_W-1:0] seq_q;
  logic             overflow_q;
  logic [7:0]       drop_q;

  logic             push;
  logic             fifo_full;
  logic             fifo_valid;
  logic             drop;
  trace_rec_t       push_rec;

  assign push     = mem_q.valid;
  assign push_rec = slot_to_rec(mem_q, cycle_q);
  // A full FIFO still accepts the retire if the head leaves on the same edge.
  assign drop     = push && fifo_full && !(fifo_valid && bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      ex_q       <= '0;
      mem_q      <= '0;
      cycle_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (!bus.stall) begin
        if (bus.if_valid && !bus.flush) begin
          id_q.valid     <= 1'b1;
          id_q.seq       <= seq_q;
          id_q.pc        <= bus.if_pc;
          id_q.instr     <= bus.if_instr;
          id_q.fetch_cyc <= cycle_q;
          id_q.stall_cyc <= 4'd0;
          seq_q          <= seq_q + 1'b1;
        end else begin
          id_q <= '0;
        end
        ex_q <= id_q;
      end else begin
        // Stall takes priority over flush: ID holds, a bubble enters EX.
        if (id_q.valid && (id_q.stall_cyc != STALL_SAT))
          id_q.stall_cyc <= id_q.stall_cyc + 1'b1;
        ex_q <= '0;
      end
      mem_q <= ex_q;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .full      (fifo_full),
    .out_valid (fifo_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_rec)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.cycle     = cycle_q;

endmodule

// File: tb/tb_pipeline_retire_tracker.sv
// Directed bench for pipeline_retire_tracker with a scoreboard queue of
// expected retire records built from the bench's own cycle/seq model.
module tb_pipeline_retire_tracker;
  import wisc_trace_pkg::*;

  localparam int REC_W = $bits(trace_rec_t);

  logic clk;
  logic rst_n;

  pipeline_retire_tracker_if bus ();

  pipeline_retire_tracker #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and model state
  logic [REC_W-1:0] exp_q[$];
  int               total = 0;
  int               bad   = 0;
  int               pops  = 0;
  logic [CYC_W-1:0] tb_cyc = '0;
  logic [SEQ_W-1:0] tb_seq = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the record stream for the upcoming edge, then advance one clock.
  task automatic cycle();
    logic [REC_W-1:0] e;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rec", bus.out_valid, 1'b0);
      end else if (bus.out_ready) begin
        e = exp_q.pop_front();
        chk("rec", bus.out_rec, e);
        pops++;
      end else begin
        chk("hold_head", bus.out_rec, exp_q[0]);
      end
    end
    @(posedge clk);
    if (rst_n) tb_cyc = tb_cyc + 1'b1;
    @(negedge clk);
  endtask

  // Present one instruction for one edge; keep=0 means it will be dropped.
  task automatic fetch(input logic [15:0] pc, input int stalls, input bit keep);
    trace_rec_t r;
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = pc ^ 16'hA5C3;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    r.seq        = tb_seq;
    r.pc         = pc;
    r.instr      = pc ^ 16'hA5C3;
    r.fetch_cyc  = tb_cyc;
    r.retire_cyc = tb_cyc + 32'd3 + 32'(stalls);
    r.stall_cyc  = 4'(stalls);
    if (keep) exp_q.push_back(r);
    tb_seq = tb_seq + 1'b1;
    cycle();
    bus.if_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
    chk("drain_left", exp_q.size(), 0);
    cycle();
    cycle();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.if_valid  = 1'b0;
    bus.if_pc     = '0;
    bus.if_instr  = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_drop_cnt", bus.drop_cnt, 8'd0);
    chk("rst_cycle", bus.cycle, 32'd0);
    rst_n  = 1'b1;
    tb_cyc = '0;
    cycle();
    cycle();
    chk("cycle_count", bus.cycle, tb_cyc);

    // 1: three back-to-back fetches, retire at cycles 5,6,7
    bus.out_ready = 1'b1;
    fetch(16'h0000, 0, 1'b1);
    fetch(16'h0002, 0, 1'b1);
    fetch(16'h0004, 0, 1'b1);
    drain(12);

    // 2: two stall cycles while in ID
    fetch(16'h0010, 2, 1'b1);
    bus.stall = 1'b1;
    cycle();
    cycle();
    bus.stall = 1'b0;
    drain(12);

    // 3: flushed instruction leaves no record and consumes no seq
    bus.if_valid = 1'b1;
    bus.if_pc    = 16'h0020;
    bus.if_instr = 16'h0020 ^ 16'hA5C3;
    bus.flush    = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    fetch(16'h0022, 0, 1'b1);
    drain(12);

    // 4: consumer blocked, six retires into a 4-deep FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) fetch(16'h0040 + 16'(2 * i), 0, i < 4);
    repeat (3) cycle();
    chk("ovf_valid", bus.out_valid, 1'b1);
    chk("ovf_sticky", bus.overflow, 1'b1);
    chk("ovf_drop_cnt", bus.drop_cnt, 8'd2);

    // 5: full FIFO, retire and pop on the same edge
    fetch(16'h0060, 0, 1'b1);
    cycle();
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    chk("full_pop_drop_cnt", bus.drop_cnt, 8'd2);
    chk("full_pop_overflow", bus.overflow, 1'b1);
    bus.out_ready = 1'b1;
    pops = 0;
    drain(12);
    chk("full_pop_occupancy", pops, 4);

    // 6: reset with records queued and three in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fetch(16'h0070 + 16'(2 * i), 0, 1'b1);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_cycle", bus.cycle, 32'd0);
    chk("mid_rst_overflow", bus.overflow, 1'b0);
    chk("mid_rst_drop_cnt", bus.drop_cnt, 8'd0);
    exp_q.delete();
    tb_seq = '0;
    tb_cyc = '0;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("post_rst_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    fetch(16'h0080, 0, 1'b1);
    drain(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
